qmr_fault_monitor: RTL
======================

QMR_FAULT_MONITOR -- requirements
Module: qmr_fault_monitor

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of every saturating error counter.
REQ-002 SHALL have parameter PERSIST_TH, default 4, range 1..15, consecutive disagreeing samples that declare an ALU faulty.
REQ-003 SHALL have port clk, input, 1, the single clock; all state on its rising edge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port sample_valid, input, 1, vote counts valid this cycle.
REQ-006 SHALL have ports alu1_vote_count..alu5_vote_count, input, 3 each, agreement count per ALU (self included) from the voter.
REQ-007 SHALL have port clear_faults, input, 1, clears fault state only.
REQ-008 SHALL have port clear_counters, input, 1, clears statistics counters only.
REQ-009 SHALL have ports err_cnt1..err_cnt5, output, CNT_W each, disagreement totals per ALU.
REQ-010 SHALL have port nomaj_cnt, output, CNT_W, count of samples with no majority.
REQ-011 SHALL have port fault_mask, output, 5, bit i-1 set means ALU i declared faulty.
REQ-012 SHALL have port health_state, output, 2: 00 NORMAL, 01 DEGRADED, 10 FAILED.
REQ-013 SHALL have ports evt_valid (output, 1), evt_ready (input, 1), evt_type (output, 2: 01 ALU fault, 10 no majority), evt_alu (output, 3: 1..5, 0 for no majority).
REQ-014 SHALL have port evt_overflow, output, 1, sticky flag for dropped events.

Function
REQ-015 Sample accepted only when sample_valid=1; otherwise no state changes except clears and event handshake.
REQ-016 Majority exists when any vote count >= 3; ALU i disagrees when majority exists and its count <= 2.
REQ-017 Accepted sample with no majority: nomaj_cnt += 1 (saturating); streaks unchanged; FAILED entered.
REQ-018 Per ALU streak counter: +1 on disagree, saturates at PERSIST_TH, cleared to 0 on agree.
REQ-019 fault_mask[i] set at the edge where streak reaches PERSIST_TH; sticky until reset or clear_faults; visible 1 cycle after the PERSIST_TH-th disagreeing sample.
REQ-020 err_cntN += 1 per disagreeing sample, saturating at 2^CNT_W-1, no wrap.
REQ-021 health_state registered and updated at the same edge as fault_mask: popcount 0 -> NORMAL; 1..2 -> DEGRADED; >=3 -> FAILED.
REQ-022 FAILED is sticky until reset or clear_faults, even when popcount falls.
REQ-023 Event generated on a fault_mask bit's 0->1 transition (type 01, evt_alu = ALU index) and on the first no-majority sample after reset or clear (type 10, evt_alu 0).
REQ-024 Event presented the cycle after its triggering sample; evt_valid held, payload stable, until evt_valid && evt_ready.
REQ-025 Single-entry event register: a new event while evt_valid=1 and evt_ready=0 is dropped and sets evt_overflow.
REQ-026 New event in the same cycle as an accepted handshake loads the new event; no drop.
REQ-027 Simultaneous events in one cycle: no-majority wins, else the lowest ALU index; the rest dropped and evt_overflow set.
REQ-028 clear_faults: clears fault_mask, streaks, FAILED latch, no-majority-seen flag and evt_overflow; health_state -> NORMAL next cycle; takes priority over the same-cycle sample's fault updates; counters untouched.
REQ-029 clear_counters: zeroes err_cnt1..5 and nomaj_cnt; takes priority over same-cycle increments.

Reset
REQ-030 reset SHALL zero all counters, streaks, fault_mask, evt_valid, evt_overflow and flags, and set health_state NORMAL at the next edge; it overrides all inputs, including mid-handshake and mid-streak.

Verification
REQ-031 All counts 5 for 10 samples -> all counters 0, fault_mask 00000, NORMAL, no event.
REQ-032 PERSIST_TH=4; ALU3 count 1, others 4, for 4 samples -> err_cnt3=4, fault_mask 00100 and DEGRADED one cycle later, event type 01 / alu 3; an agreeing sample after 3 disagreeing samples resets the streak and sets no fault.
REQ-033 Counts 2,2,2,2,1 on one sample -> nomaj_cnt=1, FAILED, event type 10 / alu 0; clear_faults -> NORMAL, nomaj_cnt still 1.
REQ-034 evt_ready=0; ALU1 and ALU2 faulted in the same cycle -> event alu 1, evt_overflow=1; then evt_ready=1 -> evt_valid drops the next cycle.
REQ-035 CNT_W=4; 20 disagreeing samples -> err_cnt saturates at 15; reset asserted mid-run -> all outputs zero and NORMAL the next cycle.

Source files
------------

// File: rtl/qmr_fault_monitor.sv
// qmr_fault_monitor: watches per-ALU agreement counts from a five-way voter,
// tracks persistent disagreement, declares faulty ALUs, keeps saturating error
// statistics, derives an overall health state and raises a single-entry event
// stream (ALU fault / loss of majority) with a sticky overflow flag.
module qmr_fault_monitor #(
  parameter int CNT_W      = 16,
  parameter int PERSIST_TH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sample_valid,
  input  logic [2:0]       alu1_vote_count,
  input  logic [2:0]       alu2_vote_count,
  input  logic [2:0]       alu3_vote_count,
  input  logic [2:0]       alu4_vote_count,
  input  logic [2:0]       alu5_vote_count,
  input  logic             clear_faults,
  input  logic             clear_counters,
  output logic [CNT_W-1:0] err_cnt1,
  output logic [CNT_W-1:0] err_cnt2,
  output logic [CNT_W-1:0] err_cnt3,
  output logic [CNT_W-1:0] err_cnt4,
  output logic [CNT_W-1:0] err_cnt5,
  output logic [CNT_W-1:0] nomaj_cnt,
  output logic [4:0]       fault_mask,
  output logic [1:0]       health_state,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [1:0]       evt_type,
  output logic [2:0]       evt_alu,
  output logic             evt_overflow
);

  // Streaks never need to count past the threshold, which is at most 15.
  localparam logic [3:0]       STREAK_TH = 4'(PERSIST_TH);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [1:0]       EVT_FAULT = 2'b01;
  localparam logic [1:0]       EVT_NOMAJ = 2'b10;

  typedef enum logic [1:0] {
    NORMAL   = 2'b00,
    DEGRADED = 2'b01,
    FAILED   = 2'b10
  } health_t;

  // Registered state
  logic [CNT_W-1:0] err_q [5];
  logic [CNT_W-1:0] nomaj_q;
  logic [3:0]       streak_q [5];
  logic [4:0]       mask_q;
  health_t          health_q;
  logic             failed_q;
  logic             nomaj_seen_q;
  logic             evt_valid_q;
  logic [1:0]       evt_type_q;
  logic [2:0]       evt_alu_q;
  logic             evt_ovf_q;

  // Next-state values
  logic [CNT_W-1:0] err_d [5];
  logic [CNT_W-1:0] nomaj_d;
  logic [3:0]       streak_d [5];
  logic [4:0]       mask_d;
  health_t          health_d;
  logic             failed_d;
  logic             nomaj_seen_d;
  logic             evt_valid_d;
  logic [1:0]       evt_type_d;
  logic [2:0]       evt_alu_d;
  logic             evt_ovf_d;

  // Decode helpers
  logic [2:0] votes [5];
  logic       majority;
  logic       accept_maj;
  logic       nomaj_sample;
  logic [4:0] disagree;
  logic [4:0] fault_set;
  logic [4:0] fault_rise;
  logic       nomaj_evt;
  logic [2:0] mask_pop;
  logic [2:0] rise_pop;
  logic [2:0] cand_count;
  logic [1:0] cand_type;
  logic [2:0] cand_alu;
  logic       can_load;
  logic       drop;

  // Classify the current sample: majority present, and which ALUs sit outside it.
  always_comb begin
    votes[0] = alu1_vote_count;
    votes[1] = alu2_vote_count;
    votes[2] = alu3_vote_count;
    votes[3] = alu4_vote_count;
    votes[4] = alu5_vote_count;
    majority = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (votes[i] >= 3'd3) majority = 1'b1;
    end
    accept_maj   = sample_valid && majority;
    nomaj_sample = sample_valid && !majority;
    disagree     = '0;
    for (int i = 0; i < 5; i++) begin
      disagree[i] = accept_maj && (votes[i] <= 3'd2);
    end
  end

  // Persistence streaks and sticky fault mask; a no-majority sample leaves streaks alone.
  always_comb begin
    fault_set = '0;
    for (int i = 0; i < 5; i++) begin
      streak_d[i] = streak_q[i];
      if (clear_faults) begin
        streak_d[i] = 4'd0;
      end else if (accept_maj) begin
        if (disagree[i]) begin
          if (streak_q[i] != STREAK_TH) streak_d[i] = streak_q[i] + 4'd1;
          fault_set[i] = (streak_q[i] >= (STREAK_TH - 4'd1));
        end else begin
          streak_d[i] = 4'd0;
        end
      end
    end
    mask_d       = clear_faults ? 5'b00000 : (mask_q | fault_set);
    fault_rise   = clear_faults ? 5'b00000 : (fault_set & ~mask_q);
    nomaj_evt    = nomaj_sample && !nomaj_seen_q && !clear_faults;
    nomaj_seen_d = clear_faults ? 1'b0 : (nomaj_seen_q | nomaj_sample);
  end

  // Saturating statistics; a same-cycle clear beats any increment.
  always_comb begin
    nomaj_d = nomaj_q;
    for (int i = 0; i < 5; i++) err_d[i] = err_q[i];
    if (clear_counters) begin
      nomaj_d = '0;
      for (int i = 0; i < 5; i++) err_d[i] = '0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (disagree[i] && (err_q[i] != CNT_MAX)) err_d[i] = err_q[i] + CNT_W'(1);
      end
      if (nomaj_sample && (nomaj_q != CNT_MAX)) nomaj_d = nomaj_q + CNT_W'(1);
    end
  end

  // Health follows the new fault mask; FAILED latches until a fault clear.
  always_comb begin
    mask_pop = 3'd0;
    for (int i = 0; i < 5; i++) mask_pop = mask_pop + {2'b00, mask_d[i]};
    failed_d = clear_faults ? 1'b0
                            : (failed_q | nomaj_sample | (mask_pop >= 3'd3));
    if (failed_d)              health_d = FAILED;
    else if (mask_pop != 3'd0) health_d = DEGRADED;
    else                       health_d = NORMAL;
  end

  // Pick one event per cycle (no-majority first, then lowest ALU) and manage the holding register.
  always_comb begin
    rise_pop = 3'd0;
    for (int i = 0; i < 5; i++) rise_pop = rise_pop + {2'b00, fault_rise[i]};
    cand_count = rise_pop + {2'b00, nomaj_evt};
    cand_type  = EVT_FAULT;
    cand_alu   = 3'd0;
    if (nomaj_evt) begin
      cand_type = EVT_NOMAJ;
      cand_alu  = 3'd0;
    end else begin
      for (int i = 4; i >= 0; i--) begin
        if (fault_rise[i]) cand_alu = 3'(i + 1);
      end
    end
    can_load    = !evt_valid_q || evt_ready;
    evt_valid_d = evt_valid_q;
    evt_type_d  = evt_type_q;
    evt_alu_d   = evt_alu_q;
    if ((cand_count != 3'd0) && can_load) begin
      evt_valid_d = 1'b1;
      evt_type_d  = cand_type;
      evt_alu_d   = cand_alu;
    end else if (evt_valid_q && evt_ready) begin
      evt_valid_d = 1'b0;
    end
    drop      = (cand_count > 3'd1) || ((cand_count != 3'd0) && !can_load);
    evt_ovf_d = clear_faults ? 1'b0 : (evt_ovf_q | drop);
  end

  // Single state register; reset overrides every other input.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 5; i++) begin
        err_q[i]    <= '0;
        streak_q[i] <= 4'd0;
      end
      nomaj_q      <= '0;
      mask_q       <= 5'b00000;
      health_q     <= NORMAL;
      failed_q     <= 1'b0;
      nomaj_seen_q <= 1'b0;
      evt_valid_q  <= 1'b0;
      evt_type_q   <= 2'b00;
      evt_alu_q    <= 3'd0;
      evt_ovf_q    <= 1'b0;
    end else begin
      for (int i = 0; i < 5; i++) begin
        err_q[i]    <= err_d[i];
        streak_q[i] <= streak_d[i];
      end
      nomaj_q      <= nomaj_d;
      mask_q       <= mask_d;
      health_q     <= health_d;
      failed_q     <= failed_d;
      nomaj_seen_q <= nomaj_seen_d;
      evt_valid_q  <= evt_valid_d;
      evt_type_q   <= evt_type_d;
      evt_alu_q    <= evt_alu_d;
      evt_ovf_q    <= evt_ovf_d;
    end
  end

  assign err_cnt1     = err_q[0];
  assign err_cnt2     = err_q[1];
  assign err_cnt3     = err_q[2];
  assign err_cnt4     = err_q[3];
  assign err_cnt5     = err_q[4];
  assign nomaj_cnt    = nomaj_q;
  assign fault_mask   = mask_q;
  assign health_state = health_q;
  assign evt_valid    = evt_valid_q;
  assign evt_type     = evt_type_q;
  assign evt_alu      = evt_alu_q;
  assign evt_overflow = evt_ovf_q;

endmodule
